// File: rtl/seg7_pkg.sv
`default_nettype none
// == seg7_pkg : glyph constants and segment bit order for the 7-seg bank | rev 1.0 ==
package seg7_pkg;

   // Bit positions inside one 7-bit glyph: {g,f,e,d,c,b,a}
   localparam int SEG_IDX_A = 0;
   localparam int SEG_IDX_B = 1;
   localparam int SEG_IDX_C = 2;
   localparam int SEG_IDX_D = 3;
   localparam int SEG_IDX_E = 4;
   localparam int SEG_IDX_F = 5;
   localparam int SEG_IDX_G = 6;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_A     = 7'b0001000;
   localparam logic [6:0] GLYPH_B     = 7'b0000011;
   localparam logic [6:0] GLYPH_C     = 7'b1000110;
   localparam logic [6:0] GLYPH_D     = 7'b0100001;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_F     = 7'b0001110;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_ALL   = 7'b0000000;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// == seg7_glyph : nibble + mode to active-low glyph, purely combinational | rev 1.0 ==
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_hex_mode,
   output logic [6:0] o_glyph
);

   always_comb begin
      o_glyph = GLYPH_BLANK;
      case (i_nibble)
         4'h0: o_glyph = GLYPH_0;
         4'h1: o_glyph = GLYPH_1;
         4'h2: o_glyph = GLYPH_2;
         4'h3: o_glyph = GLYPH_3;
         4'h4: o_glyph = GLYPH_4;
         4'h5: o_glyph = GLYPH_5;
         4'h6: o_glyph = GLYPH_6;
         4'h7: o_glyph = GLYPH_7;
         4'h8: o_glyph = GLYPH_8;
         4'h9: o_glyph = GLYPH_9;
         4'hA: o_glyph = i_hex_mode ? GLYPH_A : GLYPH_DASH;
         4'hB: o_glyph = i_hex_mode ? GLYPH_B : GLYPH_DASH;
         4'hC: o_glyph = i_hex_mode ? GLYPH_C : GLYPH_DASH;
         4'hD: o_glyph = i_hex_mode ? GLYPH_D : GLYPH_DASH;
         4'hE: o_glyph = i_hex_mode ? GLYPH_E : GLYPH_DASH;
         4'hF: o_glyph = i_hex_mode ? GLYPH_F : GLYPH_DASH;
         default: o_glyph = GLYPH_BLANK;
      endcase
   end

endmodule : seg7_glyph
`default_nettype wire

// File: rtl/seg7_multi_digit_ctrl.sv
`default_nettype none
// == seg7_multi_digit_ctrl : registered multi-digit 7-seg driver with blink/LZB/lamp test | rev 1.0 ==
module seg7_multi_digit_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    hex_mode,
   input  logic                    lz_blank,
   input  logic                    blink_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lamp_test,
   output logic [7*NUM_DIGITS-1:0] seg_n
);

   localparam int              CNT_W      = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BLINK_DIV - 1);

   logic [4*NUM_DIGITS-1:0] r_value_q;
   logic [CNT_W-1:0]        r_blink_cnt;
   logic                    r_blink_on;
   logic [7*NUM_DIGITS-1:0] w_seg_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_value_q <= '0;
      end else if (load) begin
         r_value_q <= value;
      end
   end

   // Blink phase restarts from "on" every time the timer is disabled
   always_ff @(posedge clk) begin
      if (!rst_n || !blink_en) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == c_CNT_LAST) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   generate
      for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
         logic [6:0] w_glyph;
         logic       w_upper_zero;
         logic       w_blink_off;
         logic       w_lz_off;

         seg7_glyph u_glyph (
            .i_nibble   (r_value_q[4*k +: 4]),
            .i_hex_mode (hex_mode),
            .o_glyph    (w_glyph)
         );

         // This nibble and every more-significant one are zero
         assign w_upper_zero = (r_value_q[4*NUM_DIGITS-1 : 4*k] == '0);
         assign w_blink_off  = blink_en && blink_mask[k] && !r_blink_on;
         assign w_lz_off     = lz_blank && (k != 0) && w_upper_zero;

         assign w_seg_nxt[7*k +: 7] = lamp_test   ? GLYPH_ALL   :
                                      w_blink_off ? GLYPH_BLANK :
                                      w_lz_off    ? GLYPH_BLANK :
                                                    w_glyph;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_n <= '1;
      end else begin
         seg_n <= w_seg_nxt;
      end
   end

endmodule : seg7_multi_digit_ctrl
`default_nettype wire
